// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port main-memory arbiter: FSM state encoding
// and requester IDs.
package mem_arb_pkg;

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_ACCESS = 2'b01;
   localparam logic [1:0] ST_DONE   = 2'b10;

   localparam logic REQ_I = 1'b0;
   localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_sel2.sv
// Two-way round-robin selector: a lone requester wins; under contention the
// side that was not granted last wins.
import mem_arb_pkg::*;

module rr_sel2 (
   input  logic req_i,
   input  logic req_d,
   input  logic last_grant,
   output logic grant
);

   always_comb begin
      grant = REQ_I;
      if (req_i && req_d)
         grant = ~last_grant;
      else if (req_d)
         grant = REQ_D;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache refills and D-cache misses/write-throughs onto one
// fixed-latency main-memory port.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting; picks a requester and latches its transaction
//   ST_ACCESS | memory enabled for MEM_LAT cycles, countdown running
//   ST_DONE   | one-cycle ACK to the winner, round-robin pointer updated
import mem_arb_pkg::*;

module mem_arbiter #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              I_REQ,
   input  logic [ADDR_W-1:0] I_ADDR,
   output logic [DATA_W-1:0] I_RDATA,
   output logic              I_ACK,
   input  logic              D_REQ,
   input  logic              D_WE,
   input  logic [ADDR_W-1:0] D_ADDR,
   input  logic [DATA_W-1:0] D_WDATA,
   output logic [DATA_W-1:0] D_RDATA,
   output logic              D_ACK,
   output logic              MEM_EN,
   output logic              MEM_WE,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_WDATA,
   input  logic [DATA_W-1:0] MEM_RDATA,
   output logic              BUSY
);

   localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

   logic [1:0]        state;
   logic [3:0]        cnt;
   logic              last_grant;
   logic              owner;
   logic              grant;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   rr_sel2 u_rr_sel2 (
      .req_i      (I_REQ),
      .req_d      (D_REQ),
      .last_grant (last_grant),
      .grant      (grant)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         last_grant <= REQ_I;
         owner      <= REQ_I;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         I_RDATA    <= '0;
         D_RDATA    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (I_REQ || D_REQ) begin
                  owner   <= grant;
                  addr_q  <= (grant == REQ_D) ? D_ADDR : I_ADDR;
                  we_q    <= (grant == REQ_D) ? D_WE : 1'b0;
                  wdata_q <= (grant == REQ_D) ? D_WDATA : '0;
                  cnt     <= CNT_LOAD;
                  state   <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (cnt == 4'd0) begin
                  // Writes never disturb the D-side read-data register.
                  if (owner == REQ_I)
                     I_RDATA <= MEM_RDATA;
                  else if (!we_q)
                     D_RDATA <= MEM_RDATA;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_DONE: begin
               last_grant <= owner;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign MEM_EN    = (state == ST_ACCESS);
   assign MEM_WE    = MEM_EN && we_q;
   assign MEM_ADDR  = addr_q;
   assign MEM_WDATA = wdata_q;
   assign I_ACK     = (state == ST_DONE) && (owner == REQ_I);
   assign D_ACK     = (state == ST_DONE) && (owner == REQ_D);
   assign BUSY      = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// request mixes, scored against a transaction-level reference model.
module tb_mem_arbiter;

   localparam int ADDR_W  = 10;
   localparam int DATA_W  = 32;
   localparam int MEM_LAT = 4;

   logic              CLK, RST;
   logic              I_REQ, D_REQ, D_WE;
   logic [ADDR_W-1:0] I_ADDR, D_ADDR;
   logic [DATA_W-1:0] D_WDATA;
   logic [DATA_W-1:0] I_RDATA, D_RDATA;
   logic              I_ACK, D_ACK;
   logic              MEM_EN, MEM_WE;
   logic [ADDR_W-1:0] MEM_ADDR;
   logic [DATA_W-1:0] MEM_WDATA;
   logic [DATA_W-1:0] MEM_RDATA;
   logic              BUSY;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
      .CLK(CLK), .RST(RST),
      .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_RDATA(I_RDATA), .I_ACK(I_ACK),
      .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
      .D_RDATA(D_RDATA), .D_ACK(D_ACK),
      .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
      .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .BUSY(BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [DATA_W-1:0] hash(input logic [ADDR_W-1:0] a);
      return {a, 22'h0} ^ (32'h9E37_79B9 * {22'h0, a}) ^ 32'h0F0F_1234;
   endfunction

   // Memory environment: data is only presented in the final enabled cycle.
   logic [DATA_W-1:0] env_mem [0:(1<<ADDR_W)-1];
   logic              env_wr  [0:(1<<ADDR_W)-1];
   logic              env_clr;
   int                en_run;
   logic              force_en;
   logic [DATA_W-1:0] force_rdata;

   always @(posedge CLK) begin
      if (env_clr) begin
         for (int i = 0; i < (1 << ADDR_W); i++) env_wr[i] <= 1'b0;
      end else if (MEM_EN && MEM_WE) begin
         env_mem[MEM_ADDR] <= MEM_WDATA;
         env_wr[MEM_ADDR]  <= 1'b1;
      end
      en_run <= MEM_EN ? en_run + 1 : 0;
   end

   always_comb begin
      MEM_RDATA = 32'hBAD0_0000 | 32'(en_run);
      if (MEM_EN && en_run == MEM_LAT - 1) begin
         if (force_en)
            MEM_RDATA = force_rdata;
         else if (env_wr[MEM_ADDR])
            MEM_RDATA = env_mem[MEM_ADDR];
         else
            MEM_RDATA = hash(MEM_ADDR);
      end
   end

   // Reference model state
   logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
   logic              last_d;
   logic [DATA_W-1:0] exp_irdata, exp_drdata;
   logic [ADDR_W-1:0] exp_addr;
   logic              exp_we;
   logic [DATA_W-1:0] exp_wdata;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return hash(a);
   endfunction

   function automatic logic pick_d(input logic i, input logic d);
      if (i && d) return !last_d;
      return d;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_ack(input int budget, output int ticks, output int en_cycles,
                           output logic got_i, output logic got_d);
      ticks = 0; en_cycles = 0; got_i = 1'b0; got_d = 1'b0;
      while (ticks < budget && !(got_i || got_d)) begin
         tick();
         ticks++;
         if (MEM_EN) begin
            en_cycles++;
            chk("mem_addr", MEM_ADDR, exp_addr);
            chk("mem_we", MEM_WE, exp_we);
            if (exp_we) chk("mem_wdata", MEM_WDATA, exp_wdata);
         end
         chk("ack_exclusive", I_ACK & D_ACK, 0);
         got_i = I_ACK;
         got_d = D_ACK;
      end
      chk("ack_seen", got_i | got_d, 1);
   endtask

   task automatic serve(input logic side_d, input int exp_ticks, input int exp_en);
      int t, en;
      logic gi, gd;
      logic [DATA_W-1:0] rd_exp;
      exp_addr  = side_d ? D_ADDR : I_ADDR;
      exp_we    = side_d ? D_WE : 1'b0;
      exp_wdata = D_WDATA;
      rd_exp    = force_en ? force_rdata : ref_read(exp_addr);
      wait_ack(20, t, en, gi, gd);
      chk("ack_latency", t, exp_ticks);
      chk("mem_en_cycles", en, exp_en);
      chk("ack_i_side", gi, !side_d);
      chk("ack_d_side", gd, side_d);
      if (exp_we) ref_mem[exp_addr] = exp_wdata;
      else if (side_d) exp_drdata = rd_exp;
      else exp_irdata = rd_exp;
      chk("i_rdata", I_RDATA, exp_irdata);
      chk("d_rdata", D_RDATA, exp_drdata);
      last_d = side_d;
   endtask

   task automatic drop(input logic side_d);
      if (side_d) D_REQ = 1'b0;
      else I_REQ = 1'b0;
   endtask

   task automatic settle();
      I_REQ = 1'b0;
      D_REQ = 1'b0;
      tick();
      chk("idle_busy", BUSY, 0);
      chk("ack_one_cycle", I_ACK | D_ACK, 0);
   endtask

   // Both sides request from idle; second side waits and is served next.
   task automatic contend();
      logic first;
      I_REQ = 1'b1;
      D_REQ = 1'b1;
      first = pick_d(1'b1, 1'b1);
      serve(first, MEM_LAT + 1, MEM_LAT);
      drop(first);
      serve(!first, MEM_LAT + 2, MEM_LAT);
      settle();
   endtask

   initial begin
      RST = 1'b1; env_clr = 1'b1;
      I_REQ = 1'b0; D_REQ = 1'b0; D_WE = 1'b0;
      I_ADDR = '0; D_ADDR = '0; D_WDATA = '0;
      force_en = 1'b0; force_rdata = '0;
      last_d = 1'b0; exp_irdata = '0; exp_drdata = '0;
      exp_addr = '0; exp_we = 1'b0; exp_wdata = '0;
      repeat (3) tick();
      env_clr = 1'b0;
      chk("rst_busy", BUSY, 0);
      chk("rst_mem_en", MEM_EN, 0);
      chk("rst_mem_we", MEM_WE, 0);
      chk("rst_mem_addr", MEM_ADDR, 0);
      chk("rst_mem_wdata", MEM_WDATA, 0);
      chk("rst_acks", {I_ACK, D_ACK}, 0);
      chk("rst_i_rdata", I_RDATA, 0);
      chk("rst_d_rdata", D_RDATA, 0);
      RST = 1'b0;
      tick();

      // Contention straight after reset: D first, then I; repeated.
      for (int k = 0; k < 2; k++) begin
         I_ADDR = 10'($urandom);
         D_ADDR = 10'($urandom);
         D_WE   = 1'b0;
         contend();
      end

      // Lone I read with fixed memory data
      I_ADDR = 10'h010;
      force_en = 1'b1; force_rdata = 32'hDEAD_BEEF;
      I_REQ = 1'b1;
      serve(1'b0, MEM_LAT + 1, MEM_LAT);
      force_en = 1'b0;
      chk("i_rdata_deadbeef", I_RDATA, 32'hDEAD_BEEF);
      settle();

      // Lone D write, then read it back through the arbiter
      D_WE = 1'b1; D_ADDR = 10'h3FF; D_WDATA = 32'h1234_5678;
      D_REQ = 1'b1;
      serve(1'b1, MEM_LAT + 1, MEM_LAT);
      settle();
      D_WE = 1'b0;
      D_REQ = 1'b1;
      serve(1'b1, MEM_LAT + 1, MEM_LAT);
      chk("d_readback", D_RDATA, 32'h1234_5678);
      settle();

      // Reset in the second access cycle aborts without ACK; pointer back to I
      I_ADDR = 10'h155;
      I_REQ = 1'b1;
      tick();
      tick();
      chk("abort_pre_en", MEM_EN, 1);
      RST = 1'b1;
      tick();
      I_REQ = 1'b0;
      chk("abort_mem_en", MEM_EN, 0);
      chk("abort_busy", BUSY, 0);
      chk("abort_acks", {I_ACK, D_ACK}, 0);
      chk("abort_i_rdata", I_RDATA, 0);
      chk("abort_d_rdata", D_RDATA, 0);
      RST = 1'b0;
      exp_irdata = '0; exp_drdata = '0; last_d = 1'b0;
      for (int k = 0; k < MEM_LAT + 2; k++) begin
         tick();
         chk("abort_no_ack", {I_ACK, D_ACK, BUSY}, 0);
      end
      D_WE = 1'b0;
      contend();

      // I_REQ dropped in the first access cycle still completes
      I_ADDR = 10'h0A5;
      I_REQ = 1'b1;
      tick();
      chk("drop_first_en", MEM_EN, 1);
      I_REQ = 1'b0;
      serve(1'b0, MEM_LAT, MEM_LAT - 1);
      settle();

      // Randomized request mixes
      for (int n = 0; n < 40; n++) begin
         logic ri, rd, first;
         int   r;
         r  = $urandom_range(1, 3);
         ri = r[0];
         rd = r[1];
         I_ADDR  = 10'($urandom);
         D_ADDR  = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 7)) : 10'($urandom);
         D_WE    = 1'($urandom);
         D_WDATA = $urandom;
         I_REQ = ri;
         D_REQ = rd;
         first = pick_d(ri, rd);
         serve(first, MEM_LAT + 1, MEM_LAT);
         drop(first);
         if (ri && rd) begin
            serve(!first, MEM_LAT + 2, MEM_LAT);
            drop(!first);
         end
         settle();
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
